// File: rtl/regfile_ctrl_pkg.sv
// Purpose: shared types and sizes for the register-file writeback control slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: REG_IDX_W/NREGS sizing, requester id enum, default-width writeback request struct.
package regfile_ctrl_pkg;

    localparam int REG_IDX_W = 4;
    localparam int NREGS     = 16;
    localparam int DATA_W    = 32;

    typedef enum logic {
        REQ_A = 1'b0,   // ALU / execute result
        REQ_B = 1'b1    // load data returning from memory
    } req_id_t;

    // Default-width writeback request; the arbiter re-declares the same
    // layout at its own data width.
    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    data;
    } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Purpose: per-register pending bits for outstanding loads; flags decode reads of pending registers.
// Latency: set/clear take effect at the edge they are presented; stall is combinational from pending.
// Backpressure: none; stall is advisory to decode.
// Ports: clk/rst (sync, active-high); set_vld/set_idx reserve a register;
//        clr_vld/clr_idx release it; r_sel1/r_sel2 read selects; stall lookup result.
module regfile_scoreboard
    import regfile_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_vld,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_vld,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic [REG_IDX_W-1:0] r_sel1,
    input  logic [REG_IDX_W-1:0] r_sel2,
    output logic                 stall
);

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

    // x0 is never reserved, so pending[0] can never leave zero.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_vld && (set_idx != '0)) begin
            set_mask[set_idx] = 1'b1;
        end
        if (clr_vld) begin
            clr_mask[clr_idx] = 1'b1;
        end
    end

    // Clear is applied before set so a new reservation of the register
    // being written back in the same edge survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    assign stall = pending[r_sel1] | pending[r_sel2];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Purpose: arbitrates ALU (A) and load (B) writebacks onto the single register-file write port; tracks load-pending registers.
// Latency: 1 cycle from valid&ready to wr_en/write_register/write_value; 1 write per cycle.
// Backpressure: loser of a contention sees ready=0 and holds its request; the register file never backpressures.
// Ports: clk/rst (sync, active-high); a_* ALU request; b_* load request; rsv_* load reservation;
//        r_sel1/r_sel2/stall decode scoreboard lookup; wr_en/write_register/write_value to the file.
// Option: REGFILE_ARB_ROUND_ROBIN_EN selects round-robin between A and B; undefined gives fixed B priority.
module regfile_write_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int size = 32
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    input  logic [REG_IDX_W-1:0] a_rd,
    input  logic [size-1:0]      a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [REG_IDX_W-1:0] b_rd,
    input  logic [size-1:0]      b_data,
    output logic                 b_ready,
    input  logic                 rsv_valid,
    input  logic [REG_IDX_W-1:0] rsv_reg,
    input  logic [REG_IDX_W-1:0] r_sel1,
    input  logic [REG_IDX_W-1:0] r_sel2,
    output logic                 stall,
    output logic                 wr_en,
    output logic [REG_IDX_W-1:0] write_register,
    output logic [size-1:0]      write_value
);

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [size-1:0]      data;
    } wb_req_sz_t;

    wb_req_sz_t req_a;
    wb_req_sz_t req_b;
    wb_req_sz_t req_sel;
    logic       a_wins;
    logic       grant;
    logic       b_wr_q;     // the write now on the port came from the load side

    assign req_a = {a_rd, a_data};
    assign req_b = {b_rd, b_data};

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    req_id_t last_grant;

    // Reset to "A granted last" so the first contention goes to B.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= REQ_A;
        end else if (a_ready) begin
            last_grant <= REQ_A;
        end else if (b_ready) begin
            last_grant <= REQ_B;
        end
    end

    assign a_wins = (last_grant == REQ_B);
`else
    assign a_wins = 1'b0;
`endif

    // a_wins only matters when both requesters are valid.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            if (a_valid && (!b_valid || a_wins)) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end
        end
    end

    assign grant   = a_ready | b_ready;
    assign req_sel = a_ready ? req_a : req_b;

    // rd==0 is consumed but never written; index/data still follow the
    // grant so the port reflects the last accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en          <= 1'b0;
            write_register <= '0;
            write_value    <= '0;
            b_wr_q         <= 1'b0;
        end else begin
            wr_en  <= grant && (req_sel.rd != '0);
            b_wr_q <= b_ready && (b_rd != '0);
            if (grant) begin
                write_register <= req_sel.rd;
                write_value    <= req_sel.data;
            end
        end
    end

    // The pending bit is released at the end of the wr_en cycle, once the
    // file actually holds the load value.
    regfile_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_vld (rsv_valid),
        .set_idx (rsv_reg),
        .clr_vld (b_wr_q),
        .clr_idx (write_register),
        .r_sel1  (r_sel1),
        .r_sel2  (r_sel2),
        .stall   (stall)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Purpose: directed self-checking bench for regfile_write_arbiter.
// Latency: inputs change 1ns after the rising edge; outputs are checked 2ns after it.
// Backpressure: requests are held by the bench until their ready is seen.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic [3:0]  a_rd;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [3:0]  b_rd;
    logic [31:0] b_data;
    logic        b_ready;
    logic        rsv_valid;
    logic [3:0]  rsv_reg;
    logic [3:0]  r_sel1;
    logic [3:0]  r_sel2;
    logic        stall;
    logic        wr_en;
    logic [3:0]  write_register;
    logic [31:0] write_value;

    int n_cmp = 0;
    int n_err = 0;

    regfile_write_arbiter #(.size(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .a_valid        (a_valid),
        .a_rd           (a_rd),
        .a_data         (a_data),
        .a_ready        (a_ready),
        .b_valid        (b_valid),
        .b_rd           (b_rd),
        .b_data         (b_data),
        .b_ready        (b_ready),
        .rsv_valid      (rsv_valid),
        .rsv_reg        (rsv_reg),
        .r_sel1         (r_sel1),
        .r_sel2         (r_sel2),
        .stall          (stall),
        .wr_en          (wr_en),
        .write_register (write_register),
        .write_value    (write_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; leaves time at edge+1ns for driving inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        rsv_valid = 1'b0; rsv_reg = '0; r_sel1 = '0; r_sel2 = '0;
        tick(); tick();

        // Reserve x4 and latch an A write, then reset with both outstanding.
        rst = 1'b0;
        rsv_valid = 1'b1; rsv_reg = 4'd4;
        a_valid = 1'b1; a_rd = 4'd6; a_data = 32'h55;
        tick();
        rsv_valid = 1'b0; a_valid = 1'b0; r_sel1 = 4'd4;
        #1;
        chk("pre_rst_stall", stall, 1);
        chk("pre_rst_wr_en", wr_en, 1);
        chk("pre_rst_wreg", write_register, 6);
        rst = 1'b1; a_valid = 1'b1;
        #1;
        chk("rst_a_ready", a_ready, 0);
        tick();
        a_valid = 1'b0; rst = 1'b0;
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wreg", write_register, 0);
        chk("rst_wval", write_value, 0);
        for (int i = 0; i < 16; i++) begin
            r_sel1 = i[3:0]; r_sel2 = i[3:0];
            #1;
            chk($sformatf("rst_stall_r%0d", i), stall, 0);
        end
        r_sel1 = '0; r_sel2 = '0;

        // A only.
        a_valid = 1'b1; a_rd = 4'd5; a_data = 32'h1234;
        #1;
        chk("aonly_a_ready", a_ready, 1);
        chk("aonly_b_ready", b_ready, 0);
        tick();
        a_valid = 1'b0;
        #1;
        chk("aonly_wr_en", wr_en, 1);
        chk("aonly_wreg", write_register, 5);
        chk("aonly_wval", write_value, 32'h1234);
        tick();
        #1;
        chk("aonly_wr_en_off", wr_en, 0);
        chk("aonly_wreg_hold", write_register, 5);
        chk("aonly_wval_hold", write_value, 32'h1234);

        // Contention; A was granted last, so B wins in both modes.
        a_valid = 1'b1; a_rd = 4'd3; a_data = 32'hAAAA;
        b_valid = 1'b1; b_rd = 4'd7; b_data = 32'hBBBB;
        #1;
        chk("both1_a_ready", a_ready, 0);
        chk("both1_b_ready", b_ready, 1);
        tick();
        // B was granted; re-raise B with a new request while A still waits.
        b_rd = 4'd8; b_data = 32'hCCCC;
        #1;
        chk("both1_wr_en", wr_en, 1);
        chk("both1_wreg", write_register, 7);
        chk("both1_wval", write_value, 32'hBBBB);
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
        chk("both2_a_ready", a_ready, 1);
        chk("both2_b_ready", b_ready, 0);
        tick();
        a_valid = 1'b0;
        #1;
        chk("both2_wreg", write_register, 3);
        chk("both2_wval", write_value, 32'hAAAA);
        chk("both3_b_ready", b_ready, 1);
        tick();
        b_valid = 1'b0;
        #1;
        chk("both3_wreg", write_register, 8);
        chk("both3_wval", write_value, 32'hCCCC);
`else
        chk("both2_a_ready", a_ready, 0);
        chk("both2_b_ready", b_ready, 1);
        tick();
        b_valid = 1'b0;
        #1;
        chk("both2_wreg", write_register, 8);
        chk("both2_wval", write_value, 32'hCCCC);
        chk("both3_a_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        #1;
        chk("both3_wreg", write_register, 3);
        chk("both3_wval", write_value, 32'hAAAA);
`endif
        chk("both3_wr_en", wr_en, 1);
        tick();
        #1;
        chk("idle_wr_en", wr_en, 0);

        // Scoreboard: reserve x9, then write it back from the load side.
        rsv_valid = 1'b1; rsv_reg = 4'd9; r_sel1 = 4'd9; r_sel2 = 4'd0;
        #1;
        chk("sb_stall_before", stall, 0);
        tick();
        rsv_valid = 1'b0;
        #1;
        chk("sb_stall_sel1", stall, 1);
        r_sel1 = 4'd2; r_sel2 = 4'd9;
        #1;
        chk("sb_stall_sel2", stall, 1);
        b_valid = 1'b1; b_rd = 4'd9; b_data = 32'h99;
        #1;
        chk("sb_b_ready", b_ready, 1);
        tick();
        b_valid = 1'b0;
        #1;
        chk("sb_wr_en", wr_en, 1);
        chk("sb_wreg", write_register, 9);
        chk("sb_stall_wr_cycle", stall, 1);
        tick();
        #1;
        chk("sb_stall_cleared", stall, 0);

        // Set and clear of x9 on the same edge: set wins.
        rsv_valid = 1'b1; rsv_reg = 4'd9;
        tick();
        rsv_valid = 1'b0;
        b_valid = 1'b1; b_rd = 4'd9; b_data = 32'h100;
        tick();
        b_valid = 1'b0;
        rsv_valid = 1'b1; rsv_reg = 4'd9;
        tick();
        rsv_valid = 1'b0;
        #1;
        chk("sb_set_wins", stall, 1);
        b_valid = 1'b1; b_rd = 4'd9; b_data = 32'h101;
        tick();
        b_valid = 1'b0;
        tick();
        #1;
        chk("sb_final_clear", stall, 0);

        // x0: load to x0 is accepted but never written; x0 cannot be reserved.
        b_valid = 1'b1; b_rd = 4'd0; b_data = 32'hDEAD;
        #1;
        chk("x0_b_ready", b_ready, 1);
        tick();
        b_valid = 1'b0;
        #1;
        chk("x0_wr_en", wr_en, 0);
        rsv_valid = 1'b1; rsv_reg = 4'd0; r_sel1 = 4'd0; r_sel2 = 4'd0;
        tick();
        rsv_valid = 1'b0;
        #1;
        chk("x0_stall", stall, 0);
        tick();
        #1;
        chk("x0_stall_later", stall, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 16-entry register file between two writeback requesters:
  - A: ALU/execute result.
  - B: load data returning from memory.
- Also keeps a per-register pending scoreboard for outstanding loads, so decode can stall reads of registers not yet written back.
- Sits between execute/load units and the register file; drives the file's write_register, write_value and wr_en.

Parameters:
- size, 32, data width of write values.
- NREGS, 16, number of architectural registers; index width is 4 bits, fixed.

Ports:
- clk  input  1  system clock; one clock domain.
- rst  input  1  reset, synchronous, active-high.
- a_valid  input  1  ALU writeback request.
- a_rd  input  4  ALU destination register.
- a_data  input  size  ALU result.
- a_ready  output  1  ALU request accepted this cycle.
- b_valid  input  1  load writeback request.
- b_rd  input  4  load destination register.
- b_data  input  size  load data.
- b_ready  output  1  load request accepted this cycle.
- rsv_valid  input  1  decode issues a load; reserve rsv_reg.
- rsv_reg  input  4  register reserved by the issued load.
- r_sel1  input  4  decode read select 1.
- r_sel2  input  4  decode read select 2.
- stall  output  1  a read select hits a pending register.
- wr_en  output  1  register file write enable (registered).
- write_register  output  4  register file write index (registered).
- write_value  output  size  register file write data (registered).

Behaviour:
- Reset (rst=1 at clk edge):
  - wr_en=0, write_register=0, write_value=0.
  - pending[15:0]=0.
  - Priority state favours B.
  - a_ready/b_ready are combinational and read 0 while rst=1.
- Arbitration (combinational, each cycle):
  - Only A valid: a_ready=1.
  - Only B valid: b_ready=1.
  - Both valid: exactly one ready, per priority rule (see Optional Feature).
  - Loser's ready=0; it holds valid/rd/data stable until accepted.
- Acceptance: valid&ready at edge N latches rd/data. During cycle N+1:
  - write_register=rd, write_value=data, wr_en=1 for exactly one cycle.
  - Latency 1, throughput 1 write/cycle, no backpressure from the register file.
- No grant in a cycle: wr_en=0 next cycle. write_register/write_value hold their last values.
- rd==0: request is accepted (ready asserted) but wr_en stays 0 in N+1. x0 is never written.
- Scoreboard:
  - rsv_valid at an edge sets pending[rsv_reg]. rsv_reg==0 is ignored.
  - A B-grant at edge N clears pending[b_rd] at edge N+1, i.e. at the end of the wr_en cycle. stall drops in cycle N+2, when the file holds the new value.
  - Set and clear of the same register at the same edge: set wins.
  - Reserving an already-pending register leaves it set, with no count.
  - A-grants never touch the scoreboard.
- stall = pending[r_sel1] | pending[r_sel2]. Purely combinational. pending[0] is always 0.
- Reset mid-operation: any latched-but-unwritten request is dropped (wr_en=0 after the reset edge). All pending bits are cleared.

Optional Feature:
- Macro: REGFILE_ARB_ROUND_ROBIN_EN.
- Defined: round-robin between A and B.
  - A one-bit last-grant register updates on every grant.
  - When both are valid, the requester not granted last wins.
  - Reset state makes B win the first contention.
- Undefined: fixed priority. B (load) always wins when both are valid; the last-grant register is not built.

Decomposition:
- Package regfile_ctrl_pkg:
  - REG_IDX_W=4, NREGS=16.
  - Requester enum {REQ_A, REQ_B}.
  - Typedef for the writeback request struct {rd, data}.
- Sub-module regfile_scoreboard: 16-bit pending vector; set/clear/priority logic; stall lookup.
- The arbiter and write-out registers stay in the top module.

Test Plan:
- Reset with pending writes outstanding -> cycle after reset: wr_en=0, stall=0 for all r_sel, write_register=0.
- A only: a_valid, a_rd=5, a_data=0x1234 -> a_ready=1 same cycle; next cycle wr_en=1, write_register=5, write_value=0x1234; following cycle wr_en=0.
- Both valid (A rd=3 0xAAAA, B rd=7 0xBBBB), held for 2 cycles:
  - Fixed: B written first, then A.
  - Round-robin: B, then A; a repeat contention then grants B.
- Scoreboard:
  - rsv_valid rsv_reg=9; r_sel1=9 -> stall=1 next cycle.
  - B write rd=9 accepted at edge N -> wr_en at N+1, stall=0 from N+2.
  - Simultaneous rsv 9 and B clear of 9 -> stall stays 1.
- x0 handling:
  - B rd=0 -> b_ready=1, wr_en remains 0.
  - rsv_reg=0 -> stall never asserts for r_sel=0.
